// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - round-robin writeback arbiter with pending-write scoreboard
module reg_wb_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [4:0]       alu_addr,
    input  logic [31:0]      alu_data,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  logic [4:0]       mem_addr,
    input  logic [31:0]      mem_data,
    output logic             mem_ready,
    input  logic             rsv_valid,
    input  logic [4:0]       rsv_addr,
    output logic             reg_wr,
    output logic [4:0]       reg_write_addr,
    output logic [31:0]      reg_din,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] conflict_cnt
);

    // last_grant: 0 = ALU won last, 1 = MEM won last
    logic             last_grant_q, last_grant_d;
    logic             reg_wr_q, reg_wr_d;
    logic [4:0]       reg_addr_q, reg_addr_d;
    logic [31:0]      reg_din_q, reg_din_d;
    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             alu_gnt;
    logic             mem_gnt;
    logic             acc;
    logic [4:0]       acc_addr;
    logic [31:0]      acc_data;

    // Grant decision: a lone requester always wins; on a tie the one that did not win last time wins
    always_comb begin
        alu_gnt  = !rst && alu_valid && (!mem_valid || last_grant_q);
        mem_gnt  = !rst && mem_valid && (!alu_valid || !last_grant_q);
        acc      = alu_gnt || mem_gnt;
        acc_addr = alu_gnt ? alu_addr : mem_addr;
        acc_data = alu_gnt ? alu_data : mem_data;
    end

    // Next-state for the write port, round-robin pointer, scoreboard and conflict counter
    always_comb begin
        last_grant_d = last_grant_q;
        reg_wr_d     = 1'b0;
        reg_addr_d   = reg_addr_q;
        reg_din_d    = reg_din_q;
        pending_d    = pending_q;
        cnt_d        = cnt_q;

        if (acc) begin
            last_grant_d = mem_gnt;
            reg_wr_d     = (acc_addr != 5'd0);
            reg_addr_d   = acc_addr;
            reg_din_d    = acc_data;
        end

        // Clear on retirement first so a same-cycle reservation (a newer producer) overrides it
        for (int i = 1; i < 32; i++) begin
            if (rsv_valid && (rsv_addr == i[4:0])) begin
                pending_d[i] = 1'b1;
            end else if (acc && (acc_addr == i[4:0])) begin
                pending_d[i] = 1'b0;
            end
        end
        pending_d[0] = 1'b0;

        if (alu_valid && mem_valid && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers; reset drops any in-flight write immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            reg_wr_q     <= 1'b0;
            reg_addr_q   <= 5'd0;
            reg_din_q    <= 32'd0;
            pending_q    <= 32'd0;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_wr_q     <= reg_wr_d;
            reg_addr_q   <= reg_addr_d;
            reg_din_q    <= reg_din_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
        end
    end

    assign alu_ready      = alu_gnt;
    assign mem_ready      = mem_gnt;
    assign reg_wr         = reg_wr_q;
    assign reg_write_addr = reg_addr_q;
    assign reg_din        = reg_din_q;
    assign pending        = pending_q;
    assign conflict_cnt   = cnt_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - scoreboard bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alu_valid = 1'b0;
    logic [4:0]       alu_addr = '0;
    logic [31:0]      alu_data = '0;
    logic             alu_ready;
    logic             mem_valid = 1'b0;
    logic [4:0]       mem_addr = '0;
    logic [31:0]      mem_data = '0;
    logic             mem_ready;
    logic             rsv_valid = 1'b0;
    logic [4:0]       rsv_addr = '0;
    logic             reg_wr;
    logic [4:0]       reg_write_addr;
    logic [31:0]      reg_din;
    logic [31:0]      pending;
    logic [CNT_W-1:0] conflict_cnt;

    reg_wb_arbiter #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .mem_valid      (mem_valid),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .rsv_valid      (rsv_valid),
        .rsv_addr       (rsv_addr),
        .reg_wr         (reg_wr),
        .reg_write_addr (reg_write_addr),
        .reg_din        (reg_din),
        .pending        (pending),
        .conflict_cnt   (conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // expected write-port contents: {wr, addr, data}
    logic [37:0] exp_q[$];

    // reference model state
    logic             m_lg;
    logic [31:0]      m_pend;
    logic [CNT_W-1:0] m_cnt;
    logic [4:0]       m_addr;
    logic [31:0]      m_din;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_lg   = 1'b1;
        m_pend = '0;
        m_cnt  = '0;
        m_addr = '0;
        m_din  = '0;
        exp_q.delete();
    endtask

    // One clock cycle: entered and left at a negedge
    task automatic do_cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                            input logic mv, input logic [4:0] ma, input logic [31:0] md,
                            input logic rv, input logic [4:0] ra);
        logic        ga, gm, acc;
        logic [4:0]  xa;
        logic [31:0] xd;
        logic [37:0] e;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        rsv_valid = rv; rsv_addr = ra;
        #1;
        ga  = av && (!mv || m_lg);
        gm  = mv && (!av || !m_lg);
        acc = ga || gm;
        xa  = ga ? aa : ma;
        xd  = ga ? ad : md;
        check("alu_ready", {63'd0, alu_ready}, {63'd0, ga});
        check("mem_ready", {63'd0, mem_ready}, {63'd0, gm});
        if (acc) begin
            exp_q.push_back({xa != 5'd0, xa, xd});
            m_lg = gm;
            if (!(rv && ra == xa)) m_pend[xa] = 1'b0;
        end
        if (rv && ra != 5'd0) m_pend[ra] = 1'b1;
        if (av && mv && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            m_addr = e[36:32];
            m_din  = e[31:0];
            check("reg_wr", {63'd0, reg_wr}, {63'd0, e[37]});
        end else begin
            check("reg_wr_idle", {63'd0, reg_wr}, 64'd0);
        end
        check("reg_write_addr", {59'd0, reg_write_addr}, {59'd0, m_addr});
        check("reg_din", {32'd0, reg_din}, {32'd0, m_din});
        check("pending", {32'd0, pending}, {32'd0, m_pend});
        check("conflict_cnt", {{(64-CNT_W){1'b0}}, conflict_cnt}, {{(64-CNT_W){1'b0}}, m_cnt});
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        // reset with a request present: readies must stay low
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h1;
        @(negedge clk); @(negedge clk);
        check("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
        check("rst_reg_wr", {63'd0, reg_wr}, 64'd0);
        check("rst_pending", {32'd0, pending}, 64'd0);
        check("rst_cnt", {60'd0, conflict_cnt}, 64'd0);
        alu_valid = 1'b0;
        rst = 1'b0;

        // idle
        for (int i = 0; i < 2; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // single ALU write, then idle shows hold
        do_cycle(1, 5'd5, 32'h0000000A, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // contention: ALU, MEM, ALU, MEM
        for (int i = 0; i < 4; i++) do_cycle(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0);
        check("cnt_after_4", {60'd0, conflict_cnt}, 64'd4);

        // x0 write accepted but not issued; reserving x0 ignored
        do_cycle(0, 0, 0, 1, 5'd0, 32'hFFFFFFFC, 1, 5'd0);
        check("pending0", {63'd0, pending[0]}, 64'd0);

        // scoreboard on r31
        do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd31);
        check("pend31_set", {63'd0, pending[31]}, 64'd1);
        do_cycle(1, 5'd31, 32'hDEAD0031, 0, 0, 0, 0, 0);
        check("pend31_clr", {63'd0, pending[31]}, 64'd0);
        do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd31);
        do_cycle(1, 5'd31, 32'hBEEF0031, 0, 0, 0, 1, 5'd31);
        check("pend31_rsv_wins", {63'd0, pending[31]}, 64'd1);

        // mixed random traffic with reservations
        for (int i = 0; i < 12; i++)
            do_cycle(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                     1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                     1'($urandom_range(0, 1)), 5'($urandom));

        // counter saturation
        for (int i = 0; i < 20; i++) do_cycle(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 0, 0);
        check("cnt_sat", {60'd0, conflict_cnt}, 64'd15);

        // mid-stream reset while a write is on the port
        do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd12);
        do_cycle(1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
        check("pre_rst_reg_wr", {63'd0, reg_wr}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_reg_wr", {63'd0, reg_wr}, 64'd0);
        check("mid_rst_pending", {32'd0, pending}, 64'd0);
        check("mid_rst_cnt", {60'd0, conflict_cnt}, 64'd0);
        check("mid_rst_addr", {59'd0, reg_write_addr}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // tie after reset goes to ALU first
        do_cycle(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
